rsa_modexp: RTL and testbench

Parametrised modular-exponentiation engine, the successor to the fixed 128-bit rsa block. It loads a key (modulus N, then exponent E) over a valid/ready port and then accepts message words. For each message it computes M^E mod N by left-to-right square-and-multiply, using a bit-serial interleaved modular multiplier. It sits between the key/message sources (PS/2 front end, AES output) and the downstream output consumer; stall freezes it.

---
 rtl/rsa_modexp.sv | 111 +++++++++++
 tb/tb_rsa_modexp.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp.sv
// rsa_modexp: modular exponentiation M^E mod N by left-to-right square-and-multiply
// Ports:
//   clk, rst (sync, active-low), stall (global freeze)
//   key_data_i/key_valid_i/key_ready_o : key beats, N first then E
//   key_reload_i                       : drop key and return to key load (only while waiting for a message)
//   msg_data_i/msg_valid_i/msg_ready_o : message M
//   out_data_o/out_err_o/out_valid_o/out_ready_i : result, error flag for illegal operands
// Build option: define RSA_MODEXP_LZSKIP_EN to skip the squarings for leading zero bits of E.
module rsa_modexp #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic [W-1:0] key_data_i,
   input  logic         key_valid_i,
   output logic         key_ready_o,
   input  logic         key_reload_i,
   input  logic [W-1:0] msg_data_i,
   input  logic         msg_valid_i,
   output logic         msg_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_err_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);
   localparam int CW = $clog2(W);
   typedef enum logic [2:0] {KEY_N, KEY_E, WAIT_MSG, SQR, MUL, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0] n, e, m, r, b;
   logic [W+1:0] p, p_sum, p_s1, p_nx;
   logic [CW-1:0] cnt, j, j_init;
   logic key_acc, msg_acc, out_acc, bad, last, busy, e_zero, err;
   assign key_ready_o = !stall && (state == KEY_N || state == KEY_E);
   assign msg_ready_o = !stall && state == WAIT_MSG && !key_reload_i;
   assign key_acc = key_valid_i && key_ready_o;
   assign msg_acc = msg_valid_i && msg_ready_o;
   assign out_acc = !stall && out_valid_o && out_ready_i;
   assign bad = n < W'(2) || msg_data_i >= n;
   assign busy = state == SQR || state == MUL;
   assign last = cnt == '0;
   // One bit of the interleaved multiply: P = 2P + A[i]*B, then two conditional
   // subtractions bring 2P+B (< 3N) back below N.
   assign b = state == MUL ? m : r;
   assign p_sum = {p[W:0], 1'b0} + (r[cnt] ? {2'b00, b} : '0);
   assign p_s1 = p_sum >= {2'b00, n} ? p_sum - {2'b00, n} : p_sum;
   assign p_nx = p_s1 >= {2'b00, n} ? p_s1 - {2'b00, n} : p_s1;
`ifdef RSA_MODEXP_LZSKIP_EN
   always_comb begin
      j_init = '0;
      for (int k = 0; k < W; k++) j_init = e[k] ? CW'(k) : j_init;
   end
   assign e_zero = e == '0;
`else
   assign j_init = CW'(W - 1);
   assign e_zero = 1'b0;
`endif
   always_ff @(posedge clk)
      if (!rst) state <= KEY_N;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (!stall)
         case (state)
            KEY_N:    state_nx = key_acc ? KEY_E : KEY_N;
            KEY_E:    state_nx = key_acc ? WAIT_MSG : KEY_E;
            WAIT_MSG: state_nx = key_reload_i ? KEY_N : !msg_acc ? WAIT_MSG : (bad || e_zero) ? DONE : SQR;
            SQR, MUL: state_nx = !last ? state : (state == SQR && e[j]) ? MUL : (j == '0) ? DONE : SQR;
            DONE:     state_nx = out_acc ? WAIT_MSG : DONE;
            default:  state_nx = KEY_N;
         endcase
   end
   always_ff @(posedge clk)
      if (!rst) begin
         n <= '0;
         e <= '0;
         m <= '0;
         r <= '0;
         p <= '0;
         cnt <= '0;
         j <= '0;
         err <= 1'b0;
         out_data_o <= '0;
         out_err_o <= 1'b0;
         out_valid_o <= 1'b0;
      end else if (!stall) begin
         if (key_acc && state == KEY_N) n <= key_data_i;
         if (key_acc && state == KEY_E) e <= key_data_i;
         if (msg_acc) begin
            m <= msg_data_i;
            r <= bad ? '1 : W'(1);
            err <= bad;
            p <= '0;
            cnt <= CW'(W - 1);
            j <= j_init;
         end
         if (busy) begin
            p <= last ? '0 : p_nx;
            cnt <= last ? CW'(W - 1) : cnt - 1'b1;
            if (last) r <= p_nx[W-1:0];
            // j steps down only when leaving a bit position (no MUL pending, not the final bit)
            if (last && !(state == SQR && e[j]) && j != '0) j <= j - 1'b1;
         end
         if (state == DONE && !out_valid_o) begin
            out_valid_o <= 1'b1;
            out_data_o <= r;
            out_err_o <= err;
         end
         if (out_acc) out_valid_o <= 1'b0;
      end
endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: randomized and directed checks of rsa_modexp at W=8 and W=128
module tb_rsa_modexp;
   logic clk = 0, rst = 0, stall = 0;
   always #5 clk = ~clk;
   logic [7:0] kd = 0, md = 0, od;
   logic kv = 0, kr, krl = 0, mv = 0, mr, oe, ov, ordy = 0;
   logic [127:0] kd_b = 0, md_b = 0, od_b;
   logic kv_b = 0, kr_b, krl_b = 0, mv_b = 0, mr_b, oe_b, ov_b, ordy_b = 0;
   int n_checks = 0, n_fail = 0;
   localparam int NS = 1000000;
   rsa_modexp #(.W(8)) d8 (.clk(clk), .rst(rst), .stall(stall), .key_data_i(kd), .key_valid_i(kv),
      .key_ready_o(kr), .key_reload_i(krl), .msg_data_i(md), .msg_valid_i(mv), .msg_ready_o(mr),
      .out_data_o(od), .out_err_o(oe), .out_valid_o(ov), .out_ready_i(ordy));
   rsa_modexp #(.W(128)) d128 (.clk(clk), .rst(rst), .stall(stall), .key_data_i(kd_b), .key_valid_i(kv_b),
      .key_ready_o(kr_b), .key_reload_i(krl_b), .msg_data_i(md_b), .msg_valid_i(mv_b), .msg_ready_o(mr_b),
      .out_data_o(od_b), .out_err_o(oe_b), .out_valid_o(ov_b), .out_ready_i(ordy_b));

   function automatic logic [7:0] model(int n, int e, int m);
      longint res = 1;
      for (int k = 0; k < e; k++) res = (res * m) % n;
      return 8'(res);
   endfunction

   function automatic int lat(int e, int w);
      int pc = 0, sq = w;
      for (int k = 0; k < 32; k++) pc += (e >> k) & 1;
`ifdef RSA_MODEXP_LZSKIP_EN
      if (e == 0) return 1;
      for (int k = 0; k < 32; k++) if ((e >> k) & 1) sq = k + 1;
`endif
      return w * (sq + pc) + 1;
   endfunction

   task automatic send_key(input logic [7:0] v);
      int t = 0;
      @(negedge clk); kd = v; kv = 1;
      while (!kr && t < 100) begin @(negedge clk); t++; end
      n_checks++;
      if (kr !== 1'b1) begin n_fail++; $display("FAIL key_handshake: key_ready_o=%b required 1", kr); end
      @(posedge clk); #1 kv = 0;
   endtask

   task automatic reload_key(input logic [7:0] n, input logic [7:0] e);
      @(negedge clk); krl = 1;
      @(posedge clk); #1 krl = 0;
      n_checks++;
      if (kr !== 1'b1) begin n_fail++; $display("FAIL reload: key_ready_o=%b required 1", kr); end
      send_key(n);
      send_key(e);
   endtask

   task automatic run_msg(input string name, input logic [7:0] m, input logic [7:0] exp_d,
                          input logic exp_e, input int exp_lat, input int stall_at, input bit hold);
      int t = 0, lt = 0;
      @(negedge clk); md = m; mv = 1;
      while (!mr && t < 100) begin @(negedge clk); t++; end
      n_checks++;
      if (mr !== 1'b1) begin n_fail++; $display("FAIL %s msg_handshake: msg_ready_o=%b required 1", name, mr); end
      @(posedge clk); #1 mv = 0;
      while (ov !== 1'b1 && lt < 20000) begin
         stall = lt >= stall_at && lt < stall_at + 5;
         #1;
         if (stall) begin
            n_checks++;
            if ({kr, mr} !== 2'b00) begin n_fail++; $display("FAIL %s stall_ready: key/msg ready=%b required 00", name, {kr, mr}); end
         end
         @(posedge clk); #1 lt++;
      end
      stall = 0;
      n_checks++;
      if (lt !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", name, lt, exp_lat); end
      n_checks++;
      if (od !== exp_d) begin n_fail++; $display("FAIL %s data: got %0d required %0d", name, od, exp_d); end
      n_checks++;
      if (oe !== exp_e) begin n_fail++; $display("FAIL %s err: got %b required %b", name, oe, exp_e); end
      if (hold)
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ov, od, mr} !== {1'b1, exp_d, 1'b0}) begin
               n_fail++; $display("FAIL %s hold: valid/data/msg_ready=%b/%0d/%b required 1/%0d/0", name, ov, od, mr, exp_d);
            end
         end
      @(negedge clk); ordy = 1;
      @(posedge clk); #1 ordy = 0;
      n_checks++;
      if ({ov, mr} !== 2'b01) begin n_fail++; $display("FAIL %s after_handshake: valid/msg_ready=%b required 01", name, {ov, mr}); end
   endtask

   task automatic test_reset;
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ov, od, oe, mr, kr} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL reset8: valid/data/err/msg_ready/key_ready=%b/%0d/%b/%b/%b required 0/0/0/0/1", ov, od, oe, mr, kr);
      end
      n_checks++;
      if ({ov_b, od_b, oe_b, mr_b, kr_b} !== {1'b0, 128'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL reset128: valid/err/msg_ready/key_ready=%b/%b/%b/%b required 0/0/0/1", ov_b, oe_b, mr_b, kr_b);
      end
      rst = 1;
   endtask

   task automatic test_basic;
      reload_key(8'd187, 8'd7);
      run_msg("basic", 8'd88, 8'd11, 1'b0, lat(7, 8), NS, 0);
   endtask

   task automatic test_back_to_back;
      reload_key(8'd187, 8'd23);
      run_msg("b2b_1", 8'd11, 8'd88, 1'b0, lat(23, 8), NS, 0);
      run_msg("b2b_2", 8'd88, model(187, 23, 88), 1'b0, lat(23, 8), NS, 0);
   endtask

   task automatic test_errors;
      reload_key(8'd187, 8'd7);
      run_msg("err_m_ge_n", 8'd200, 8'hFF, 1'b1, 1, NS, 0);
      reload_key(8'd1, 8'd7);
      run_msg("err_n_lt_2", 8'd0, 8'hFF, 1'b1, 1, NS, 0);
   endtask

   task automatic test_e_zero_hold;
      reload_key(8'd187, 8'd0);
      run_msg("e_zero", 8'd5, 8'd1, 1'b0, lat(0, 8), NS, 1);
      run_msg("m_zero", 8'd0, 8'd1, 1'b0, lat(0, 8), NS, 0);
      reload_key(8'd187, 8'd9);
      run_msg("m_zero_e9", 8'd0, 8'd0, 1'b0, lat(9, 8), NS, 0);
   endtask

   task automatic test_stall;
      reload_key(8'd187, 8'd7);
      run_msg("stall", 8'd88, 8'd11, 1'b0, lat(7, 8) + 5, 3, 0);
   endtask

   task automatic test_rst_mid_mul;
`ifdef RSA_MODEXP_LZSKIP_EN
      int mid = 11;
`else
      int mid = 51;
`endif
      reload_key(8'd187, 8'd7);
      run_msg("pre_rst", 8'd88, 8'd11, 1'b0, lat(7, 8), NS, 0);
      @(negedge clk); md = 8'd88; mv = 1;
      @(posedge clk); #1 mv = 0;
      repeat (mid) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;
      n_checks++;
      if ({ov, od, oe, mr, kr} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL rst_mid_mul: valid/data/err/msg_ready/key_ready=%b/%0d/%b/%b/%b required 0/0/0/0/1", ov, od, oe, mr, kr);
      end
      rst = 1;
   endtask

   task automatic test_random;
      for (int i = 0; i < 6; i++) begin
         int n, e, m;
         n = $urandom_range(255, 2);
         e = $urandom_range(255, 0);
         reload_key(8'(n), 8'(e));
         for (int k = 0; k < 3; k++) begin
            m = $urandom_range(255, 0);
            if (k < 2) m = m % n;
            if (m >= n) run_msg("rand_err", 8'(m), 8'hFF, 1'b1, 1, NS, 0);
            else run_msg("rand", 8'(m), model(n, e, m), 1'b0, lat(e, 8), NS, 0);
         end
      end
   endtask

   task automatic test_w128;
      int t, lt;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk); kd_b = b == 0 ? {1'b0, {127{1'b1}}} : 128'd3; kv_b = 1;
         t = 0;
         while (!kr_b && t < 100) begin @(negedge clk); t++; end
         n_checks++;
         if (kr_b !== 1'b1) begin n_fail++; $display("FAIL w128_key: key_ready_o=%b required 1", kr_b); end
         @(posedge clk); #1 kv_b = 0;
      end
      @(negedge clk); md_b = 128'd2; mv_b = 1;
      t = 0;
      while (!mr_b && t < 100) begin @(negedge clk); t++; end
      @(posedge clk); #1 mv_b = 0;
      lt = 0;
      while (ov_b !== 1'b1 && lt < 20000) begin @(posedge clk); #1 lt++; end
      n_checks++;
      if (lt !== lat(3, 128)) begin n_fail++; $display("FAIL w128 latency: got %0d required %0d", lt, lat(3, 128)); end
      n_checks++;
      if (od_b !== 128'd8 || oe_b !== 1'b0) begin n_fail++; $display("FAIL w128 data: got %0h err %b required 8 err 0", od_b, oe_b); end
      @(negedge clk); ordy_b = 1;
      @(posedge clk); #1 ordy_b = 0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_errors;
      test_e_zero_hold;
      test_stall;
      test_random;
      test_rst_mid_mul;
      test_w128;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
